inst_rom: RTL and testbench



---
 rtl/inst_rom_pkg.sv | 26 ++
 rtl/inst_rom_loader.sv | 171 +++++++++++++++++
 rtl/inst_rom.sv | 70 +++++++
 tb/tb_inst_rom.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_pkg.sv
// Shared types and constants for the instruction ROM and its byte-serial loader.
// Replaces the old precompiled.v defines with typed package items.
package inst_rom_pkg;

  localparam int INST_W            = 32;
  localparam int INST_ADDR_W       = 32;
  localparam int INST_MEM_NUM_LOG2 = 10;

  localparam logic [INST_W-1:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic              CHIP_ENABLE  = 1'b1;
  localparam logic              CHIP_DISABLE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5
  } load_state_e;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/inst_rom_loader.sv
// Byte-serial program loader: length header, big-endian word assembly and an
// XOR checksum trailer, driving a single write port into the instruction array.
module inst_rom_loader
  import inst_rom_pkg::*;
#(
  parameter int ADDR_WIDTH = INST_MEM_NUM_LOG2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_start_i,
  input  logic                  load_valid_i,
  input  logic [7:0]            load_byte_i,
  output logic                  load_ready_o,
  output logic                  busy_o,
  output logic                  load_done_o,
  output logic                  load_err_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [INST_W-1:0]     wdata_o
);

  localparam logic [16:0] DEPTH_L = 17'(2 ** ADDR_WIDTH);

  load_state_e state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] wcount_q, wcount_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] asm_q, asm_d;
  logic [7:0]  csum_q, csum_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic        accept_s;
  logic        we_s;

  assign accept_s = load_valid_i && ready_q;

  // Next-state logic for the load session FSM and its datapath.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wcount_d   = wcount_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    we_s       = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load_start_i) begin
          state_d    = ST_LEN_HI;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          len_d      = 16'h0000;
          wcount_d   = 16'h0000;
          byte_idx_d = 2'd0;
          csum_d     = 8'h00;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_HI: begin
        if (accept_s) begin
          len_d[15:8] = load_byte_i;
          csum_d      = csum_step(csum_q, load_byte_i);
          state_d     = ST_LEN_LO;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_LO: begin
        if (accept_s) begin
          len_d[7:0] = load_byte_i;
          csum_d     = csum_step(csum_q, load_byte_i);
          if ({len_q[15:8], load_byte_i} == 16'h0000) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          csum_d = csum_step(csum_q, load_byte_i);
          if (byte_idx_q == 2'd3) begin
            // Words past the end of the array are consumed but never written.
            if ({1'b0, wcount_q} < DEPTH_L) begin
              we_s = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            wcount_d   = wcount_q + 16'd1;
            byte_idx_d = 2'd0;
            if (wcount_d == len_q) begin
              state_d = ST_CSUM;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            asm_d      = {asm_q[15:0], load_byte_i};
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_CSUM: begin
        if (accept_s) begin
          if (load_byte_i != csum_q) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    ready_d = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
              (state_d == ST_DATA)   || (state_d == ST_CSUM);
  end

  // Session state registers; the memory itself lives in the parent.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      len_q      <= 16'h0000;
      wcount_q   <= 16'h0000;
      byte_idx_q <= 2'd0;
      asm_q      <= 24'h00_0000;
      csum_q     <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wcount_q   <= wcount_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

  assign load_ready_o = ready_q;
  assign busy_o       = busy_q;
  assign load_done_o  = done_q;
  assign load_err_o   = err_q;
  assign we_o         = we_s;
  assign waddr_o      = wcount_q[ADDR_WIDTH-1:0];
  assign wdata_o      = {asm_q, load_byte_i};

endmodule

// File: rtl/inst_rom.sv
// Instruction memory for the core fetch port: combinational word read plus a
// run-time byte-serial loader. The array is deliberately not cleared by reset.
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int ADDR_WIDTH = INST_MEM_NUM_LOG2,
  parameter int DATA_WIDTH = INST_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [INST_ADDR_W-1:0] addr,
  output logic [DATA_WIDTH-1:0]  inst,
  input  logic                   load_start,
  input  logic                   load_valid,
  input  logic [7:0]             load_byte,
  output logic                   load_ready,
  output logic                   busy,
  output logic                   load_done,
  output logic                   load_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  we_s;
  logic [ADDR_WIDTH-1:0] waddr_s;
  logic [INST_W-1:0]     wdata_s;
  logic                  busy_s;
  logic                  in_range_s;
  logic                  addr_unused_s;

  inst_rom_loader #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_loader (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_start_i (load_start),
    .load_valid_i (load_valid),
    .load_byte_i  (load_byte),
    .load_ready_o (load_ready),
    .busy_o       (busy_s),
    .load_done_o  (load_done),
    .load_err_o   (load_err),
    .we_o         (we_s),
    .waddr_o      (waddr_s),
    .wdata_o      (wdata_s)
  );

  assign busy          = busy_s;
  assign in_range_s    = (addr[INST_ADDR_W-1:ADDR_WIDTH+2] == '0);
  assign addr_unused_s = ^addr[1:0];

  // Loader write port into the word array.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[waddr_s] <= DATA_WIDTH'(wdata_s);
    end
  end

  // Fetch mux: NOP while disabled, loading, or outside the array.
  always_comb begin
    if ((ce == CHIP_ENABLE) && !busy_s && in_range_s) begin
      inst = mem_q[addr[ADDR_WIDTH+1:2]];
    end else begin
      inst = DATA_WIDTH'(ZERO_WORD);
    end
  end

endmodule

// File: tb/tb_inst_rom.sv
// Scoreboard bench for inst_rom: byte streams are built from word lists, the
// expected words are queued as they are sent and compared on read-back.
module tb_inst_rom;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_ready;
  logic        busy;
  logic        load_done;
  logic        load_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } rd_t;

  rd_t         sb_q[$];
  logic [31:0] wq[$];
  logic [31:0] model_mem [1024];

  always #5 clk = ~clk;

  inst_rom #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .addr       (addr),
    .inst       (inst),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_ready (load_ready),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic read_word(input logic [31:0] a, input logic c, output logic [31:0] got);
    ce   = c;
    addr = a;
    #1;
    got = inst;
  endtask

  task automatic start_load(input bit with_valid);
    load_start = 1'b1;
    load_valid = with_valid;
    load_byte  = 8'hFF;
    @(negedge clk);
    load_start = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    load_valid = 1'b1;
    load_byte  = b;
    while (!load_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!load_ready) begin
      checks++;
      failures++;
      $display("FAIL send_byte_timeout got ready=%b exp ready=1", load_ready);
    end
    @(negedge clk);
    load_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_stream(input logic [15:0] len, input bit corrupt, input int gap,
                             input int spurious_at);
    logic [7:0] cs;
    logic [7:0] b;
    int         nb;
    cs = 8'h00;
    nb = 0;
    start_load(1'b0);
    send_byte(len[15:8], gap);
    cs = cs ^ len[15:8];
    send_byte(len[7:0], gap);
    cs = cs ^ len[7:0];
    for (int i = 0; i < wq.size(); i++) begin
      for (int k = 3; k >= 0; k--) begin
        b = wq[i][k*8 +: 8];
        send_byte(b, gap);
        cs = cs ^ b;
        nb++;
        if (nb == spurious_at) begin
          load_start = 1'b1;
          @(negedge clk);
          load_start = 1'b0;
        end
      end
      if (i < 1024) begin
        model_mem[i] = wq[i];
        sb_q.push_back('{addr: 32'(i * 4), data: wq[i]});
      end
    end
    send_byte(corrupt ? (cs ^ 8'h01) : cs, gap);
  endtask

  task automatic test_reset();
    logic [31:0] got;
    rst = 1'b1; ce = 1'b0; addr = 32'h0; load_start = 1'b0; load_valid = 1'b0; load_byte = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, load_ready, load_done, load_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=%b", {busy, load_ready, load_done, load_err}, 4'b0000);
    end
    read_word(32'h0000_0004, 1'b0, got);
    checks++;
    if (got !== 32'h0) begin
      failures++;
      $display("FAIL reset_ce_off got=%h exp=%h", got, 32'h0);
    end
  endtask

  task automatic test_load_good();
    rd_t         e;
    logic [31:0] got;
    logic [7:0]  cs;
    wq = '{32'h3401_0010, 32'h3402_0020};
    // start and a stray byte in the same IDLE cycle: only the start may count
    start_load(1'b1);
    checks++;
    if ({busy, load_ready} !== 2'b11) begin
      failures++;
      $display("FAIL good_after_start got=%b exp=%b", {busy, load_ready}, 2'b11);
    end
    cs = 8'h00 ^ 8'h02 ^ 8'h34 ^ 8'h01 ^ 8'h00 ^ 8'h10 ^ 8'h34 ^ 8'h02 ^ 8'h00 ^ 8'h20;
    foreach (wq[i]) begin
      model_mem[i] = wq[i];
      sb_q.push_back('{addr: 32'(i * 4), data: wq[i]});
    end
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h34, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h10, 0);
    send_byte(8'h34, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h20, 0);
    send_byte(cs, 0);
    checks++;
    if ({busy, load_ready, load_done, load_err} !== 4'b0010) begin
      failures++;
      $display("FAIL good_flags got=%b exp=%b", {busy, load_ready, load_done, load_err}, 4'b0010);
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      read_word(e.addr, 1'b1, got);
      checks++;
      if (got !== e.data) begin
        failures++;
        $display("FAIL good_read addr=%h got=%h exp=%h", e.addr, got, e.data);
      end
    end
  endtask

  task automatic test_bad_csum();
    rd_t         e;
    logic [31:0] got;
    wq = '{32'hCAFE_F00D, 32'h0BAD_C0DE};
    send_stream(16'h0002, 1'b1, 0, -1);
    checks++;
    if ({busy, load_done, load_err} !== 3'b011) begin
      failures++;
      $display("FAIL badcsum_flags got=%b exp=%b", {busy, load_done, load_err}, 3'b011);
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      read_word(e.addr, 1'b1, got);
      checks++;
      if (got !== e.data) begin
        failures++;
        $display("FAIL badcsum_read addr=%h got=%h exp=%h", e.addr, got, e.data);
      end
    end
  endtask

  task automatic test_read_masking();
    logic [31:0] got;
    start_load(1'b0);
    read_word(32'h0000_0000, 1'b1, got);
    checks++;
    if (got !== 32'h0) begin
      failures++;
      $display("FAIL mask_busy got=%h exp=%h", got, 32'h0);
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    checks++;
    if ({busy, load_ready} !== 2'b11) begin
      failures++;
      $display("FAIL zero_len_csum_state got=%b exp=%b", {busy, load_ready}, 2'b11);
    end
    send_byte(8'h00, 0);
    checks++;
    if ({busy, load_done, load_err} !== 3'b010) begin
      failures++;
      $display("FAIL zero_len_flags got=%b exp=%b", {busy, load_done, load_err}, 3'b010);
    end
    read_word(32'h0000_0004, 1'b0, got);
    checks++;
    if (got !== 32'h0) begin
      failures++;
      $display("FAIL mask_ce_off got=%h exp=%h", got, 32'h0);
    end
    read_word(32'h0000_1000, 1'b1, got);
    checks++;
    if (got !== 32'h0) begin
      failures++;
      $display("FAIL mask_out_of_range got=%h exp=%h", got, 32'h0);
    end
    read_word(32'h0000_0007, 1'b1, got);
    checks++;
    if (got !== model_mem[1]) begin
      failures++;
      $display("FAIL byte_offset_ignored got=%h exp=%h", got, model_mem[1]);
    end
  endtask

  task automatic test_rst_mid();
    rd_t         e;
    logic [31:0] got;
    start_load(1'b0);
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    model_mem[0] = 32'h1122_3344;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, load_ready, load_done, load_err} !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid_flags got=%b exp=%b", {busy, load_ready, load_done, load_err}, 4'b0000);
    end
    read_word(32'h0000_0000, 1'b1, got);
    checks++;
    if (got !== model_mem[0]) begin
      failures++;
      $display("FAIL rstmid_retained got=%h exp=%h", got, model_mem[0]);
    end
    wq = '{32'hDEAD_BEEF, 32'h00C0_FFEE};
    send_stream(16'h0002, 1'b0, 0, -1);
    checks++;
    if ({busy, load_done, load_err} !== 3'b010) begin
      failures++;
      $display("FAIL rstmid_reload_flags got=%b exp=%b", {busy, load_done, load_err}, 3'b010);
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      read_word(e.addr, 1'b1, got);
      checks++;
      if (got !== e.data) begin
        failures++;
        $display("FAIL rstmid_read addr=%h got=%h exp=%h", e.addr, got, e.data);
      end
    end
  endtask

  task automatic test_gapped();
    rd_t         e;
    logic [31:0] got;
    wq = '{32'h3401_0010, 32'h3402_0020};
    send_stream(16'h0002, 1'b0, 2, 3);
    checks++;
    if ({busy, load_done, load_err} !== 3'b010) begin
      failures++;
      $display("FAIL gapped_flags got=%b exp=%b", {busy, load_done, load_err}, 3'b010);
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      read_word(e.addr, 1'b1, got);
      checks++;
      if (got !== e.data) begin
        failures++;
        $display("FAIL gapped_read addr=%h got=%h exp=%h", e.addr, got, e.data);
      end
    end
  endtask

  task automatic test_overflow();
    rd_t         e;
    logic [31:0] got;
    wq.delete();
    for (int i = 0; i < 1025; i++) begin
      wq.push_back(32'h5A00_0000 | 32'(i * 3));
    end
    send_stream(16'h0401, 1'b0, 0, -1);
    checks++;
    if ({busy, load_done, load_err} !== 3'b011) begin
      failures++;
      $display("FAIL overflow_flags got=%b exp=%b", {busy, load_done, load_err}, 3'b011);
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      read_word(e.addr, 1'b1, got);
      checks++;
      if (got !== e.data) begin
        failures++;
        $display("FAIL overflow_read addr=%h got=%h exp=%h", e.addr, got, e.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_good();
    test_bad_csum();
    test_read_masking();
    test_rst_mid();
    test_gapped();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
